// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_amsb, r_bmsb, r_bout, r_ovf;
    logic             w_d, w_br;

    assign w_d  = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_br    <= bin;
                    r_amsb  <= a[WIDTH-1];
                    r_bmsb  <= b[WIDTH-1];
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br;
                    r_cnt  <= r_cnt + 1'b1;
                    // last bit: w_d becomes diff MSB, so overflow is decided here
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_bout  <= w_br;
                        r_ovf   <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
                        r_state <= DONE;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  minuend, unsigned/two's-complement.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
REQ-013 ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; IDLE on reset.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept: on an edge with in_valid=1 in IDLE, latch a, b and bin into internal shift/borrow registers, clear the bit counter and enter SHIFT.
REQ-017 SHIFT: process one bit per edge, LSB first; d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-018 SHIFT: each d SHALL be shifted into diff from the MSB side, so diff is bit-ordered after WIDTH edges; operand registers shift right by 1.
REQ-019 Bit counter SHALL count 0..WIDTH-1; the edge that processes bit WIDTH-1 enters DONE.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH edges after the accept edge.
REQ-021 bout = final br; ovf is computed from latched operand MSBs and diff[MSB]; both valid with out_valid.
REQ-022 DONE: diff, bout and ovf SHALL be held stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-023 No bypass: in_ready SHALL rise on the cycle after the DONE->IDLE edge; minimum initiation interval is WIDTH+2 cycles.
REQ-024 in_valid in SHIFT/DONE SHALL be ignored; operand input changes after accept SHALL NOT affect the result.
REQ-025 out_ready outside DONE SHALL be ignored.
REQ-026 diff, bout and ovf SHALL retain the last result in IDLE until the next accept; outputs are undefined-free (never X after reset).

Reset
REQ-027 rst=1 SHALL, on the same edge, force IDLE, in_ready=1 on the next cycle, out_valid=0, diff=0, bout=0, ovf=0, counter=0, internal registers=0.
REQ-028 Reset SHALL take priority over accept, shift and out handshake, including mid-SHIFT and in DONE; the aborted operation produces no output.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x3C, bin=0 -> exactly 8 edges after accept: out_valid=1, diff=0x1E, bout=0, ovf=0.
REQ-030 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-031 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle a/b/in_valid -> outputs stable, in_ready=0; out_ready=1 -> IDLE, then in_ready=1 one cycle later.
REQ-033 Assert rst after 3 SHIFT edges -> all outputs 0, in_ready=1; a new op a=0x05, b=0x03 then gives diff=0x02, bout=0 after 8 edges.
REQ-034 Back-to-back: 100 random operand sets with random in_valid/out_ready gaps -> every result matches a-b-bin with correct bout/ovf; no drops or duplicates.
